// File: rtl/fetch_stage_pkg.sv
// Shared ISA definitions for the front end: word geometry, opcode map and
// the fetch-stage control state encoding.
package fetch_stage_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned OPC_W       = 5;
  localparam int unsigned INSTR_BYTES = 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [OPC_W-1:0]  opcode_t;

  // Opcode map in bits 15:11, shared with decode.
  localparam opcode_t OPC_HALT = 5'b00000;
  localparam opcode_t OPC_NOP  = 5'b00001;
  localparam opcode_t OPC_ADD  = 5'b00010;
  localparam opcode_t OPC_SUB  = 5'b00011;
  localparam opcode_t OPC_AND  = 5'b00100;
  localparam opcode_t OPC_OR   = 5'b00101;
  localparam opcode_t OPC_LD   = 5'b01000;
  localparam opcode_t OPC_ST   = 5'b01001;
  localparam opcode_t OPC_BEQ  = 5'b10000;
  localparam opcode_t OPC_BNE  = 5'b10001;
  localparam opcode_t OPC_JMP  = 5'b11000;
  localparam opcode_t OPC_JAL  = 5'b11001;

  localparam word_t   ISA_RESET_PC = 16'h0000;
  localparam opcode_t ISA_HALT_OPC = OPC_HALT;
  localparam word_t   ISA_NOP      = {OPC_NOP, 11'h000};

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetchState_t;

  function automatic opcode_t opcodeOf(input word_t w);
    return w[WORD_W-1 -: OPC_W];
  endfunction

  // Sequential successor; wraps modulo 2^16.
  function automatic word_t nextPc(input word_t pc);
    return pc + word_t'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_stage_buf.sv
// Hold buffer: keeps a fetched word (and its valid bit) while decode stalls.
module fetch_buf
  import fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [WORD_W-1:0] dataIn,
  output logic              holdValid,
  output logic [WORD_W-1:0] holdWord
);

  // Clear wins over load so a redirect always empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      holdValid <= 1'b0;
      holdWord  <= '0;
    end else if (clear) begin
      holdValid <= 1'b0;
      holdWord  <= '0;
    end else if (load) begin
      holdValid <= 1'b1;
      holdWord  <= dataIn;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory request, a one-entry hold buffer
// for decode back-pressure, redirect with in-flight response discard, halt.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = ISA_RESET_PC,
  parameter logic [OPC_W-1:0]  HALT_OPC = ISA_HALT_OPC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_data,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc_plus2,
  input  logic              instr_stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              halted
);

  fetchState_t state, stateNext;
  word_t       pc, pcNext;
  word_t       dropAddr, dropAddrNext;
  logic        dropPending, dropPendingNext;

  logic        bufLoad, bufClear, holdValid;
  word_t       holdWord;

  logic        reqActive, present, transfer, inHalt;
  word_t       addrSel, presentWord;

  fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (bufLoad),
    .clear     (bufClear),
    .dataIn    (imem_data),
    .holdValid (holdValid),
    .holdWord  (holdWord)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      dropPending <= 1'b0;
      dropAddr    <= '0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      dropPending <= dropPendingNext;
      dropAddr    <= dropAddrNext;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    stateNext       = state;
    pcNext          = pc;
    dropPendingNext = dropPending;
    dropAddrNext    = dropAddr;
    bufLoad         = 1'b0;
    bufClear        = 1'b0;
    reqActive       = 1'b0;
    addrSel         = pc;
    present         = 1'b0;
    presentWord     = '0;
    inHalt          = 1'b0;
    transfer        = 1'b0;

    unique case (state)
      FETCH: begin
        reqActive   = 1'b1;
        // A squashed request keeps its original address until it returns.
        if (dropPending) addrSel = dropAddr;
        present     = imem_ready && !dropPending;
        presentWord = imem_data;
      end
      HOLD: begin
        present     = holdValid;
        presentWord = holdWord;
      end
      HALT: begin
        inHalt = 1'b1;
      end
      default: begin
        stateNext = FETCH;
      end
    endcase

    transfer = present && !instr_stall && !redirect;

    if (redirect) begin
      pcNext    = redirect_pc;
      bufClear  = 1'b1;
      stateNext = FETCH;
      // Still waiting on memory: the in-flight response must be thrown away.
      if (state == FETCH && !imem_ready) begin
        dropPendingNext = 1'b1;
        dropAddrNext    = dropPending ? dropAddr : pc;
      end else begin
        dropPendingNext = 1'b0;
      end
    end else if (transfer) begin
      pcNext    = nextPc(pc);
      bufClear  = 1'b1;
      stateNext = (opcodeOf(presentWord) == HALT_OPC) ? HALT : FETCH;
    end else if (present && state == FETCH) begin
      bufLoad   = 1'b1;
      stateNext = HOLD;
    end else if (state == FETCH && dropPending && imem_ready) begin
      dropPendingNext = 1'b0;
    end
  end

  // Decode-facing and memory-facing outputs; reset forces them quiet.
  always_comb begin
    imem_req    = reqActive && !rst;
    imem_addr   = addrSel;
    instr_valid = present && !redirect && !rst;
    instr       = instr_valid ? presentWord : '0;
    pc_plus2    = instr_valid ? nextPc(pc) : '0;
    halted      = inHalt && !rst;
  end

  // Protocol guards: request address stable while outstanding, quiet when halted.
  reqAddrStable: assert property (@(posedge clk) disable iff (rst)
    (imem_req && !imem_ready) |=> (imem_req && $stable(imem_addr)));

  haltQuiet: assert property (@(posedge clk) disable iff (rst)
    halted |-> (!imem_req && !instr_valid));

  holdNoReq: assert property (@(posedge clk) disable iff (rst)
    (state == HOLD) |-> !imem_req);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle tables for the corner cases, then a
// randomized run against a memory model and a behavioural fetch model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        instr_stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  int nErr;
  int nChk;
  string tag;

  fetch_stage #(.RESET_PC(16'h0000), .HALT_OPC(5'b00000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_plus2    (pc_plus2),
    .instr_stall (instr_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [15:0] data;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        eReq;
    logic [15:0] eAddr;
    logic        eValid;
    logic [15:0] eInstr;
    logic [15:0] ePc2;
    logic        eHalt;
  } vec_t;

  vec_t vq[$];

  task automatic addV(input logic r, input logic rdy, input logic [15:0] d,
                      input logic st, input logic rd, input logic [15:0] rp,
                      input logic eq, input logic [15:0] ea, input logic ev,
                      input logic [15:0] ei, input logic [15:0] ep, input logic eh);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.data = d; v.stall = st; v.redir = rd; v.rpc = rp;
    v.eReq = eq; v.eAddr = ea; v.eValid = ev; v.eInstr = ei; v.ePc2 = ep; v.eHalt = eh;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s [%s] @%0t: got %h expected %h", nm, tag, $time, act, exp);
    end
  endtask

  // Random-phase state: memory model and behavioural fetch model.
  logic [15:0] memw [32768];
  logic        busy;
  logic [15:0] reqAddr;
  int          cnt;
  logic [15:0] mPc;
  logic        mHeld, mHalted, mSkip;
  logic        expReq, expValid, rReady, rStall, rRedir;
  logic [15:0] rRpc, rData, w;

  initial begin
    nErr = 0;
    nChk = 0;
    tag  = "init";
    rst = 1'b1; imem_ready = 1'b0; imem_data = '0;
    instr_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset, ignoring any memory activity.
    addV(1,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000,0);
    addV(1,1,16'hFFFF,1,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000,0);
    // 1-cycle memory, no stall.
    addV(0,1,16'hA000,0,0,16'h0000, 1,16'h0000,1,16'hA000,16'h0002,0);
    addV(0,1,16'hA002,0,0,16'h0000, 1,16'h0002,1,16'hA002,16'h0004,0);
    addV(0,1,16'hA004,0,0,16'h0000, 1,16'h0004,1,16'hA004,16'h0006,0);
    // 3-cycle memory, stall on the word at 0004.
    addV(1,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000,0);
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000,0);
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000,0);
    addV(0,1,16'hA000,0,0,16'h0000, 1,16'h0000,1,16'hA000,16'h0002,0);
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0002,0,16'h0000,16'h0000,0);
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0002,0,16'h0000,16'h0000,0);
    addV(0,1,16'hA002,0,0,16'h0000, 1,16'h0002,1,16'hA002,16'h0004,0);
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0004,0,16'h0000,16'h0000,0);
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0004,0,16'h0000,16'h0000,0);
    addV(0,1,16'hA004,1,0,16'h0000, 1,16'h0004,1,16'hA004,16'h0006,0);
    addV(0,0,16'h1234,1,0,16'h0000, 0,16'h0000,1,16'hA004,16'h0006,0);
    addV(0,0,16'h5678,1,0,16'h0000, 0,16'h0000,1,16'hA004,16'h0006,0);
    addV(0,0,16'h1234,0,0,16'h0000, 0,16'h0000,1,16'hA004,16'h0006,0);
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0006,0,16'h0000,16'h0000,0);
    addV(0,1,16'hA006,0,0,16'h0000, 1,16'h0006,1,16'hA006,16'h0008,0);
    // Redirect to 0100 while 0008 is outstanding.
    addV(0,0,16'h0000,0,1,16'h0100, 1,16'h0008,0,16'h0000,16'h0000,0);
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0008,0,16'h0000,16'h0000,0);
    addV(0,1,16'hA008,0,0,16'h0000, 1,16'h0008,0,16'h0000,16'h0000,0);
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0100,0,16'h0000,16'h0000,0);
    addV(0,1,16'hB100,0,0,16'h0000, 1,16'h0100,1,16'hB100,16'h0102,0);
    // Redirect to 0200 coinciding with a response; then redirect out of HOLD.
    addV(0,1,16'hA102,0,1,16'h0200, 1,16'h0102,0,16'h0000,16'h0000,0);
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0200,0,16'h0000,16'h0000,0);
    addV(0,1,16'hB200,1,0,16'h0000, 1,16'h0200,1,16'hB200,16'h0202,0);
    addV(0,0,16'h0000,1,1,16'h0010, 0,16'h0000,0,16'h0000,16'h0000,0);
    // Halt word at 0010, then redirect to 0020.
    addV(0,1,16'h0000,0,0,16'h0000, 1,16'h0010,1,16'h0000,16'h0012,0);
    addV(0,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000,1);
    addV(0,0,16'h0000,1,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000,1);
    addV(0,0,16'h0000,0,1,16'h0020, 0,16'h0000,0,16'h0000,16'h0000,1);
    addV(0,1,16'hA020,0,0,16'h0000, 1,16'h0020,1,16'hA020,16'h0022,0);
    // Redirect to FFFE (with drop), then wrap to 0000.
    addV(0,0,16'h0000,0,1,16'hFFFE, 1,16'h0022,0,16'h0000,16'h0000,0);
    addV(0,1,16'hA022,0,0,16'h0000, 1,16'h0022,0,16'h0000,16'h0000,0);
    addV(0,1,16'hC0FE,0,0,16'h0000, 1,16'hFFFE,1,16'hC0FE,16'h0000,0);
    addV(0,0,16'h0000,1,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000,0);
    addV(0,1,16'hA000,0,0,16'h0000, 1,16'h0000,1,16'hA000,16'h0002,0);
    // Reset while a request is outstanding.
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0002,0,16'h0000,16'h0000,0);
    addV(1,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000,0);
    addV(0,0,16'h0000,0,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000,0);
    addV(0,1,16'hA000,0,0,16'h0000, 1,16'h0000,1,16'hA000,16'h0002,0);

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      tag         = $sformatf("row%0d", i);
      rst         = vq[i].rst;
      imem_ready  = vq[i].rdy;
      imem_data   = vq[i].data;
      instr_stall = vq[i].stall;
      redirect    = vq[i].redir;
      redirect_pc = vq[i].rpc;
      #1;
      check("req", 16'(imem_req), 16'(vq[i].eReq));
      check("valid", 16'(instr_valid), 16'(vq[i].eValid));
      check("halted", 16'(halted), 16'(vq[i].eHalt));
      if (vq[i].eReq) check("addr", imem_addr, vq[i].eAddr);
      if (vq[i].eValid || vq[i].rst) begin
        check("instr", instr, vq[i].eInstr);
        check("pc_plus2", pc_plus2, vq[i].ePc2);
      end
      @(posedge clk); #1;
    end

    // Random program image; roughly 2% halt words.
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 49) == 0) w[15:11] = 5'b00000;
      else if (w[15:11] == 5'b00000) w[15:11] = 5'b11111;
      memw[i] = w;
    end

    tag = "rnd";
    rst = 1'b1; imem_ready = 1'b0; imem_data = '0;
    instr_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    busy = 1'b0; reqAddr = '0; cnt = 0;
    mPc = 16'h0000; mHeld = 1'b0; mHalted = 1'b0; mSkip = 1'b0;

    for (int c = 0; c < 4000; c++) begin
      tag    = $sformatf("rnd%0d", c);
      rStall = ($urandom_range(0, 3) == 0);
      rRedir = ($urandom_range(0, 29) == 0);
      rRpc   = 16'($urandom) & 16'hFFFE;
      expReq = !mHeld && !mHalted;
      check("rnd_req", 16'(imem_req), 16'(expReq));
      if (imem_req && !busy) begin
        check("rnd_addr", imem_addr, mPc);
        busy    = 1'b1;
        reqAddr = imem_addr;
        cnt     = int'($urandom_range(1, 3));
      end else if (imem_req && busy) begin
        check("rnd_stable", imem_addr, reqAddr);
      end
      rReady = busy && (cnt == 1);
      rData  = rReady ? memw[reqAddr[15:1]] : 16'($urandom);

      imem_ready  = rReady;
      imem_data   = rData;
      instr_stall = rStall;
      redirect    = rRedir;
      redirect_pc = rRpc;
      #1;

      expValid = !rRedir && (mHeld || (rReady && !mSkip && !mHalted));
      check("rnd_valid", 16'(instr_valid), 16'(expValid));
      check("rnd_halted", 16'(halted), 16'(mHalted));
      if (expValid) begin
        check("rnd_instr", instr, memw[mPc[15:1]]);
        check("rnd_pc2", pc_plus2, mPc + 16'd2);
      end

      // Behavioural model: what the stage must do given this cycle's events.
      if (rRedir) begin
        mSkip   = busy && !rReady;
        mPc     = rRpc;
        mHeld   = 1'b0;
        mHalted = 1'b0;
      end else begin
        if (rReady && mSkip) mSkip = 1'b0;
        if (expValid && !rStall) begin
          mHeld = 1'b0;
          if (memw[mPc[15:1]][15:11] == 5'b00000) mHalted = 1'b1;
          mPc = mPc + 16'd2;
        end else if (expValid) begin
          mHeld = 1'b1;
        end
      end
      if (rReady) busy = 1'b0;
      else if (busy) cnt--;

      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the first fetch address after reset.
REQ-002 SHALL have parameter HALT_OPC, default 5'b00000, the instruction opcode (bits 15:11) that halts fetch.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port imem_req, output, 1, instruction memory request.
REQ-006 SHALL have port imem_addr, output, 16, request byte address.
REQ-007 SHALL have port imem_ready, input, 1, response valid this cycle.
REQ-008 SHALL have port imem_data, input, 16, response instruction word.
REQ-009 SHALL have port instr_valid, output, 1, instr/pc_plus2 valid to decode.
REQ-010 SHALL have port instr, output, 16, fetched instruction.
REQ-011 SHALL have port pc_plus2, output, 16, address of instr plus 2.
REQ-012 SHALL have port instr_stall, input, 1, decode cannot accept this cycle.
REQ-013 SHALL have port redirect, input, 1, taken branch/jump from decode/execute.
REQ-014 SHALL have port redirect_pc, input, 16, target address, valid with redirect.
REQ-015 SHALL have port halted, output, 1, fetch stopped on halt.

Function
REQ-016 SHALL keep states FETCH (request outstanding), HOLD (word held, decode stalled), HALT.
REQ-017 SHALL, in FETCH, drive imem_req=1 with imem_addr=pc held stable until imem_ready is sampled 1; one outstanding request maximum; response latency 1..N cycles.
REQ-018 SHALL, on accepted response (imem_ready=1, not dropped), present instr=imem_data, pc_plus2=pc+2, instr_valid=1 in the same cycle.
REQ-019 SHALL transfer an instruction only when instr_valid=1 and instr_stall=0.
REQ-020 SHALL, on transfer, set pc<=pc+2 (16-bit, 16'hFFFE wraps to 16'h0000) and issue the next request the following cycle.
REQ-021 SHALL, on a response with instr_stall=1, latch the word into the hold buffer, enter HOLD, keep instr/pc_plus2 stable with instr_valid=1, and drive imem_req=0.
REQ-022 SHALL leave HOLD on the first cycle instr_stall=0 (transfer), returning to FETCH.
REQ-023 SHALL, on transfer of a word whose bits 15:11 equal HALT_OPC, enter HALT: imem_req=0, instr_valid=0, halted=1.
REQ-024 SHALL, on redirect=1 in any state, set pc<=redirect_pc, clear the hold buffer, force instr_valid=0 that cycle, and enter FETCH; redirect has priority over transfer and halt.
REQ-025 SHALL, when redirect arrives while a request is outstanding and imem_ready=0, set drop_pending, keep imem_addr stable, discard the next response, then request redirect_pc.
REQ-026 SHALL, on redirect coinciding with imem_ready=1, discard that response and request redirect_pc the next cycle.
REQ-027 SHALL ignore instr_stall while instr_valid=0.

Reset
REQ-028 SHALL, while rst=1, set pc=RESET_PC, state=FETCH, drop_pending=0, imem_req=0, instr_valid=0, instr=0, pc_plus2=0, halted=0.
REQ-029 SHALL assert imem_req at RESET_PC the first cycle after rst deasserts.
REQ-030 SHALL, on rst mid-request, abandon the request; the memory model is reset with the same rst.

Structure
REQ-031 SHALL take HALT_OPC, NOP encoding, RESET_PC and the 16-bit word width from the shared ISA package, alongside the opcode constants decode uses.
REQ-032 SHALL place the hold register and its valid bit in one sub-module, fetch_buf.

Verification
REQ-033 Reset, 1-cycle memory, no stall -> addresses 0000,0002,0004 on consecutive cycles; pc_plus2 0002,0004,0006.
REQ-034 3-cycle memory latency, stall 2 cycles on word at 0004 -> instr stable 2 cycles, imem_req=0 during HOLD, next request 0006.
REQ-035 Redirect to 0100 while request at 0008 pending -> 0008 response discarded, next imem_addr=0100, instr_valid=0 until it returns.
REQ-036 Redirect to 0200 with imem_ready=1 same cycle -> response dropped, next request 0200.
REQ-037 Word 16'h0000 fetched at 0010 -> halted=1, imem_req=0 indefinitely; then redirect to 0020 -> fetch resumes at 0020.
REQ-038 pc=FFFE, no stall -> following request address 0000.
